// File: rtl/sp_fifo_ctrl.sv
// sp_fifo_ctrl: streaming FIFO built on a 16x8 single-port RAM.
// One RAM operation per cycle; writes and prefetch reads share the port and
// alternate under contention. A one-entry output register holds the FIFO head
// so the consumer never waits on a RAM read in the same cycle it pops.
module sp_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_en,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Which RAM operation was granted most recently; breaks ties fairly.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    logic [ADDR_W-1:0] wr_ptr_reg,    wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg,    rd_ptr_next;
    logic [CNT_W-1:0]  ram_cnt_reg,   ram_cnt_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] pop_data_reg,  pop_data_next;
    op_t               last_op_reg,   last_op_next;

    logic ram_full;
    logic wr_req;
    logic rd_req;
    logic grant_wr;
    logic grant_rd;
    logic pop_fire;
    logic drive_bus;

    // Requests and arbitration. rd_req uses registered state only, so
    // push_ready has no combinational dependence on pop_ready.
    always_comb begin
        ram_full   = (ram_cnt_reg == DEPTH_CNT);
        wr_req     = push_valid && !ram_full;
        rd_req     = (ram_cnt_reg != '0) && !out_valid_reg;
        grant_wr   = !rst && wr_req && (!rd_req || (last_op_reg == OP_READ));
        grant_rd   = !rst && rd_req && (!wr_req || (last_op_reg == OP_WRITE));
        push_ready = !rst && !ram_full && (!rd_req || (last_op_reg == OP_READ));
        pop_fire   = out_valid_reg && pop_ready;
    end

    // RAM pin drive: read addresses rd_ptr, write and idle address wr_ptr.
    always_comb begin
        ram_we    = grant_wr;
        ram_en    = grant_rd;
        ram_addr  = grant_rd ? rd_ptr_reg : wr_ptr_reg;
        drive_bus = grant_wr && !grant_rd;
    end

    // The data bus is driven only during a write; released otherwise so the
    // RAM can drive it on reads.
    assign ram_data = drive_bus ? push_data : {DATA_W{1'bz}};

    // Next-state: grants are exclusive, so ram_cnt moves by at most one.
    // A read can only be granted with the output register empty, so it never
    // coincides with a pop.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        ram_cnt_next   = ram_cnt_reg;
        out_valid_next = out_valid_reg;
        pop_data_next  = pop_data_reg;
        last_op_next   = last_op_reg;
        if (grant_wr) begin
            wr_ptr_next  = wr_ptr_reg + 1'b1;
            ram_cnt_next = ram_cnt_reg + 1'b1;
            last_op_next = OP_WRITE;
        end else if (grant_rd) begin
            rd_ptr_next    = rd_ptr_reg + 1'b1;
            ram_cnt_next   = ram_cnt_reg - 1'b1;
            out_valid_next = 1'b1;
            pop_data_next  = ram_data;
            last_op_next   = OP_READ;
        end
        if (pop_fire) begin
            out_valid_next = 1'b0;
        end
    end

    // State registers with synchronous reset; RAM contents are left alone and
    // simply become unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            pop_data_reg  <= '0;
            last_op_reg   <= OP_READ;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ram_cnt_reg   <= ram_cnt_next;
            out_valid_reg <= out_valid_next;
            pop_data_reg  <= pop_data_next;
            last_op_reg   <= last_op_next;
        end
    end

    // Status outputs: count includes the output register entry.
    always_comb begin
        pop_valid = out_valid_reg;
        pop_data  = pop_data_reg;
        count     = ram_cnt_reg + {{ADDR_W{1'b0}}, out_valid_reg};
        full      = ram_full;
        empty     = (count == '0);
    end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Testbench for sp_fifo_ctrl: a RAM model on the shared bus, a queue-based
// reference model compared every cycle, and directed/random phases with
// literal expectations for the key scenarios.
module tb_sp_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b1;
    logic       pop_ready = 1'b0;
    logic [7:0] push_data = 8'h00;
    wire        push_ready, pop_valid, full, empty, ram_we, ram_en;
    wire  [7:0] pop_data;
    wire  [4:0] count;
    wire  [3:0] ram_addr;
    wire  [7:0] ram_data;

    sp_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count), .full(full), .empty(empty),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_en(ram_en), .ram_data(ram_data)
    );

    // RAM: combinational read onto the bus, write at the clock edge.
    logic [7:0] mem [16];
    assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 8'hzz;
    always @(posedge clk) if (ram_we && !ram_en) mem[ram_addr] <= ram_data;

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, addresses as running counts.
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    logic       m_ov = 1'b0;
    logic [7:0] m_pd = 8'h00;
    bit         m_last_rd = 1'b1;
    int         m_wa = 0;
    int         m_ra = 0;

    initial begin
        bit m_full, rdq, wrq, gw, gr, pf;
        logic [7:0] pd;
        forever begin
            @(negedge clk);
            m_full = (mq.size() == 16);
            rdq    = (mq.size() != 0) && !m_ov;
            wrq    = push_valid && !m_full;
            gw     = !rst && wrq && (!rdq || m_last_rd);
            gr     = !rst && rdq && !gw;
            chk("push_ready", int'(push_ready), int'(!rst && !m_full && (!rdq || m_last_rd)));
            chk("ram_we", int'(ram_we), int'(gw));
            chk("ram_en", int'(ram_en), int'(gr));
            chk("we_en_excl", int'(ram_we && ram_en), 0);
            chk("ram_addr", int'(ram_addr), gr ? m_ra : m_wa);
            chk("pop_valid", int'(pop_valid), int'(m_ov));
            chk("pop_data", int'(pop_data), int'(m_pd));
            chk("count", int'(count), mq.size() + int'(m_ov));
            chk("full", int'(full), int'(m_full));
            chk("empty", int'(empty), int'(mq.size() == 0 && !m_ov));
            if (gw) chk("bus_wr", int'(ram_data), int'(push_data));
            if (gr) chk("bus_rd", int'(ram_data), int'(mq[0]));
            pf = m_ov && pop_ready;
            pd = push_data;
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_ov = 1'b0; m_pd = 8'h00; m_last_rd = 1'b1; m_wa = 0; m_ra = 0;
            end else begin
                if (pf) begin
                    popped.push_back(m_pd);
                    m_ov = 1'b0;
                end
                if (gw) begin
                    mq.push_back(pd);
                    m_wa = (m_wa + 1) % 16;
                    m_last_rd = 1'b0;
                end
                if (gr) begin
                    m_pd = mq.pop_front();
                    m_ov = 1'b1;
                    m_ra = (m_ra + 1) % 16;
                    m_last_rd = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push n items base, base+1, ... with pop_ready as currently set.
    task automatic push_seq(input int n, input logic [7:0] base, input int budget);
        int acc = 0;
        int cyc = 0;
        bit f;
        push_valid = 1'b1;
        push_data  = base;
        while (acc < n && cyc < budget) begin
            @(negedge clk);
            f = push_ready;
            step();
            cyc++;
            if (f) begin
                acc++;
                push_data = base + 8'(acc);
            end
        end
        push_valid = 1'b0;
        chk("push_seq_accepted", acc, n);
    endtask

    initial begin
        int base, idx, cyc;
        bit f, prev_we;

        // Reset held two cycles with push_valid high.
        repeat (2) begin
            step();
            chk("rst_push_ready", int'(push_ready), 0);
            chk("rst_we", int'(ram_we), 0);
            chk("rst_en", int'(ram_en), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_pop_valid", int'(pop_valid), 0);
        end
        rst = 1'b0;
        push_valid = 1'b0;
        step();

        // Fill to capacity with the consumer stalled.
        pop_ready = 1'b0;
        push_seq(17, 8'h10, 40);
        push_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("fill_push_ready", int'(push_ready), 0);
            step();
        end
        push_valid = 1'b0;
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 17);
        chk("fill_pop_data", int'(pop_data), 8'h10);
        for (int i = 0; i < 16; i++)
            chk("fill_mem", int'(mem[(i + 1) % 16]), 8'h11 + i);

        // Drain.
        base = popped.size();
        pop_ready = 1'b1;
        repeat (45) step();
        chk("drain_n", popped.size() - base, 17);
        for (int i = 0; i < 17 && base + i < popped.size(); i++)
            chk("drain_order", int'(popped[base + i]), 8'h10 + i);
        chk("drain_empty", int'(empty), 1);
        chk("drain_count", int'(count), 0);

        // Wrap: 40 pushes interleaved with pops, occupancy kept at 8 or less.
        base = popped.size();
        idx = 0;
        cyc = 0;
        while ((idx < 40 || popped.size() - base < 40) && cyc < 3000) begin
            push_valid = (idx < 40) && (count < 8) && ($urandom_range(3) != 0);
            push_data  = 8'(idx);
            pop_ready  = $urandom_range(1);
            @(negedge clk);
            f = push_valid && push_ready;
            step();
            cyc++;
            if (f) idx++;
            if (count > 8) chk("wrap_count_le8", int'(count), 8);
        end
        push_valid = 1'b0;
        chk("wrap_done", int'(cyc < 3000), 1);
        for (int i = 0; i < 40 && base + i < popped.size(); i++)
            chk("wrap_order", int'(popped[base + i]), i);

        // Contention: prefill, then push and pop continuously.
        pop_ready = 1'b0;
        push_seq(5, 8'h60, 20);
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        push_data  = 8'h70;
        @(negedge clk);
        prev_we = ~ram_we;
        for (int i = 0; i < 20; i++) begin
            chk("cont_one_op", int'(ram_we ^ ram_en), 1);
            chk("cont_alternate", int'(ram_we != prev_we), 1);
            prev_we = ram_we;
            step();
            push_data = push_data + 8'd1;
            @(negedge clk);
        end
        step();

        // Random traffic.
        repeat (400) begin
            push_valid = $urandom_range(1);
            pop_ready  = $urandom_range(1);
            push_data  = 8'($urandom);
            step();
        end

        // Mid-run reset at count 9, then a single push/pop.
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        cyc = 0;
        while (count != 0 && cyc < 100) begin step(); cyc++; end
        pop_ready = 1'b0;
        push_seq(9, 8'h30, 40);
        chk("mid_count9", int'(count), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_pop_valid", int'(pop_valid), 0);
        push_valid = 1'b1;
        push_data  = 8'hA5;
        #1;
        chk("mid_push_ready", int'(push_ready), 1);
        step();
        push_valid = 1'b0;
        chk("mid_n1_pop_valid", int'(pop_valid), 0);
        step();
        chk("mid_n2_pop_valid", int'(pop_valid), 1);
        chk("mid_n2_pop_data", int'(pop_data), 8'hA5);
        pop_ready = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
